// File: rtl/pcm_mux.sv
// Multiplexed-address ROM front end: per-channel address demux, round-robin
// arbitration onto a single ROM port, banked chip-select decode and access timeout.
module pcm_mux #(
  parameter int N_CH      = 2,
  parameter int PHASE_W   = 12,
  parameter int DW        = 8,
  parameter int BANK_BITS = 2,
  parameter int TMO       = 64
) (
  input  logic                      CLK,
  input  logic                      nRESET,
  input  logic                      MODE,
  input  logic [N_CH*PHASE_W-1:0]   CH_AD,
  input  logic [N_CH-1:0]           CH_MPX,
  input  logic [N_CH-1:0]           CH_nOE,
  output logic [N_CH*DW-1:0]        CH_D,
  output logic [N_CH-1:0]           CH_DOE,
  output logic [N_CH-1:0]           CH_VALID,
  output logic [2*PHASE_W-1:0]      A,
  output logic [2**BANK_BITS-1:0]   nCS,
  output logic                      ROM_REQ,
  input  logic                      ROM_ACK,
  input  logic [DW-1:0]             ROM_D,
  output logic [N_CH-1:0]           ERR,
  input  logic                      ERR_CLR
);

  localparam int AW    = 2 * PHASE_W;
  localparam int NCS_W = 2 ** BANK_BITS;
  localparam int GW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW    = $clog2(TMO + 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state;
  logic [N_CH-1:0]   mpx_s1, mpx_s2, mpx_d;
  logic [N_CH-1:0]   noe_s1, noe_s2, noe_d;
  logic [N_CH-1:0]   mpx_rise, mpx_fall, noe_rise, noe_fall;
  logic [AW-1:0]     addr_q [N_CH];
  logic [DW-1:0]     ch_d_q [N_CH];
  logic [N_CH-1:0]   pending;
  logic [GW-1:0]     gnt;
  logic [CW-1:0]     tmo_cnt;

  logic [GW-1:0]     pick;
  logic [GW-1:0]     rr_idx;
  logic              any_pend;
  logic [AW-1:0]     pick_addr;
  logic [NCS_W-1:0]  ncs_next;

  assign mpx_rise = mpx_s2 & ~mpx_d;
  assign mpx_fall = ~mpx_s2 & mpx_d;
  assign noe_rise = noe_s2 & ~noe_d;
  assign noe_fall = ~noe_s2 & noe_d;
  assign CH_DOE   = ~noe_s2;

  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_dout
    assign CH_D[gi*DW +: DW] = ch_d_q[gi];
  end

  // Strobes arrive from another clock domain; the third stage is the edge reference.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      mpx_s1 <= '0;
      mpx_s2 <= '0;
      mpx_d  <= '0;
      noe_s1 <= '1;
      noe_s2 <= '1;
      noe_d  <= '1;
      for (int i = 0; i < N_CH; i++) addr_q[i] <= '0;
    end else begin
      // NOTE: non-blocking everywhere in clocked logic so the chain shifts by one stage per edge.
      mpx_s1 <= CH_MPX;
      mpx_s2 <= mpx_s1;
      mpx_d  <= mpx_s2;
      noe_s1 <= CH_nOE;
      noe_s2 <= noe_s1;
      noe_d  <= noe_s2;
      for (int i = 0; i < N_CH; i++) begin
        if (mpx_rise[i]) addr_q[i][PHASE_W-1:0]  <= CH_AD[i*PHASE_W +: PHASE_W];
        if (mpx_fall[i]) addr_q[i][AW-1:PHASE_W] <= CH_AD[i*PHASE_W +: PHASE_W];
      end
    end
  end

  // Round-robin: scan downward so the channel nearest last grant + 1 is picked.
  always_comb begin
    // NOTE: every comb output gets a default first, otherwise a latch is inferred.
    pick     = gnt;
    any_pend = 1'b0;
    rr_idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      rr_idx = GW'((int'(gnt) + k) % N_CH);
      if (pending[rr_idx]) begin
        pick     = rr_idx;
        any_pend = 1'b1;
      end
    end
  end

  assign pick_addr = addr_q[pick];
  assign ncs_next  = MODE ? '1 : ~(NCS_W'(1) << pick_addr[AW-3 -: BANK_BITS]);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= S_IDLE;
      ROM_REQ  <= 1'b0;
      A        <= '0;
      nCS      <= '1;
      gnt      <= GW'(N_CH - 1);
      tmo_cnt  <= '0;
      pending  <= '0;
      CH_VALID <= '0;
      ERR      <= '0;
      // NOTE: the data hold registers are reset because they are visible outputs.
      for (int i = 0; i < N_CH; i++) ch_d_q[i] <= '0;
    end else begin
      ERR <= ERR & ~{N_CH{ERR_CLR}};
      for (int i = 0; i < N_CH; i++) begin
        if (noe_rise[i]) begin
          pending[i]  <= 1'b0;
          CH_VALID[i] <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (any_pend) begin
            gnt     <= pick;
            A       <= pick_addr;
            nCS     <= ncs_next;
            ROM_REQ <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (ROM_ACK) begin
            ch_d_q[gnt]  <= ROM_D;
            pending[gnt] <= 1'b0;
            if (!noe_s2[gnt]) CH_VALID[gnt] <= 1'b1;
            ROM_REQ      <= 1'b0;
            state        <= S_IDLE;
          end else if (tmo_cnt == CW'(TMO - 1)) begin
            ERR[gnt]     <= 1'b1;
            pending[gnt] <= 1'b0;
            ROM_REQ      <= 1'b0;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A fresh request edge outranks the completion clear above (later assignment wins).
      for (int i = 0; i < N_CH; i++) begin
        if (noe_fall[i]) pending[i] <= 1'b1;
      end
    end
  end

endmodule
